dpram_sclka_arb: RTL and testbench

DPRAM_SCLKA_ARB -- requirements
Module: dpram_sclka_arb

---
 rtl/dpram_sclka_arb.sv | 126 ++++++++++++
 tb/tb_dpram_sclka_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dpram_sclka_arb.sv
// Two-requester arbiter in front of a simple dual-port RAM (one write port, one registered read port).
// Write and read channels are arbitrated independently with round-robin pointers.
module dpram_sclka_arb #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [AWIDTH-1:0] addr0,
   input  logic [AWIDTH-1:0] addr1,
   input  logic [DWIDTH-1:0] wdata0,
   input  logic [DWIDTH-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DWIDTH-1:0] rdata,
   output logic              rstale,
   output logic              err,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_waddr,
   output logic [DWIDTH-1:0] ram_wdata,
   output logic [AWIDTH-1:0] ram_raddr,
   input  logic [DWIDTH-1:0] ram_q
);

   function automatic logic in_range(input logic [AWIDTH-1:0] a);
      return (32'(a) < 32'(DEPTH));
   endfunction

   logic              wr_last_q, wr_last_d;
   logic              rd_last_q, rd_last_d;
   logic [AWIDTH-1:0] raddr_q, raddr_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic              rstale_q, rstale_d;
   logic              roor_q, roor_d;
   logic              err_q, err_d;

   logic              wreq0_s, wreq1_s, rreq0_s, rreq1_s;
   logic              wr_gnt_s, rd_gnt_s;
   logic              wr_sel_s, rd_sel_s;
   logic [AWIDTH-1:0] waddr_s, rsel_addr_s;
   logic [DWIDTH-1:0] wdata_s;
   logic              we_s;

   // Arbitration, RAM port drive and next-state for the registered read-return path
   always_comb begin
      wreq0_s     = req0 & we0;
      wreq1_s     = req1 & we1;
      rreq0_s     = req0 & ~we0;
      rreq1_s     = req1 & ~we1;

      // Pointer holds the last winner; on contention the other requester wins
      if (wreq0_s && wreq1_s) begin
         wr_sel_s = ~wr_last_q;
      end else begin
         wr_sel_s = wreq1_s;
      end
      if (rreq0_s && rreq1_s) begin
         rd_sel_s = ~rd_last_q;
      end else begin
         rd_sel_s = rreq1_s;
      end

      wr_gnt_s    = ~rst & (wreq0_s | wreq1_s);
      rd_gnt_s    = ~rst & (rreq0_s | rreq1_s);

      waddr_s     = wr_sel_s ? addr1  : addr0;
      wdata_s     = wr_sel_s ? wdata1 : wdata0;
      rsel_addr_s = rd_sel_s ? addr1  : addr0;
      we_s        = wr_gnt_s & in_range(waddr_s);

      wr_last_d   = wr_gnt_s ? wr_sel_s : wr_last_q;
      rd_last_d   = rd_gnt_s ? rd_sel_s : rd_last_q;
      raddr_d     = rd_gnt_s ? rsel_addr_s : raddr_q;

      rvalid0_d   = rd_gnt_s & ~rd_sel_s;
      rvalid1_d   = rd_gnt_s & rd_sel_s;
      roor_d      = rd_gnt_s & ~in_range(rsel_addr_s);
      // RAM returns pre-write data when both ports hit the same word
      rstale_d    = rd_gnt_s & we_s & (waddr_s == rsel_addr_s);
      err_d       = (wr_gnt_s & ~in_range(waddr_s)) | roor_d;
   end

   // Pointer and read-return state; pointers reset so requester 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_last_q <= 1'b1;
         rd_last_q <= 1'b1;
         raddr_q   <= {AWIDTH{1'b0}};
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rstale_q  <= 1'b0;
         roor_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wr_last_q <= wr_last_d;
         rd_last_q <= rd_last_d;
         raddr_q   <= raddr_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rstale_q  <= rstale_d;
         roor_q    <= roor_d;
         err_q     <= err_d;
      end
   end

   assign gnt0      = (wr_gnt_s & ~wr_sel_s) | (rd_gnt_s & ~rd_sel_s);
   assign gnt1      = (wr_gnt_s & wr_sel_s)  | (rd_gnt_s & rd_sel_s);
   assign ram_we    = we_s;
   assign ram_waddr = waddr_s;
   assign ram_wdata = wdata_s;
   assign ram_raddr = raddr_d;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rstale    = rstale_q;
   assign err       = err_q;
   assign rdata     = roor_q ? {DWIDTH{1'b0}} : ram_q;

endmodule

// File: tb/tb_dpram_sclka_arb.sv
// Table-driven bench for dpram_sclka_arb with a behavioural registered-read RAM (DEPTH=20).
module tb_dpram_sclka_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [4:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, rstale, err, ram_we;
   logic [31:0] rdata, ram_wdata, ram_q;
   logic [4:0]  ram_waddr, ram_raddr;
   logic [31:0] mem [0:31];

   int checks = 0;
   int failures = 0;
   int step = 0;

   dpram_sclka_arb #(.AWIDTH(5), .DWIDTH(32), .DEPTH(20)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .rstale(rstale), .err(err), .ram_we(ram_we),
      .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // RAM model: word i preloads to 0x1000_0000+i; read is registered and returns old data on collision
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      end else if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
      ram_q <= mem[ram_raddr];
   end

   typedef struct {
      logic r0, w0; logic [4:0] a0; logic [31:0] d0;
      logic r1, w1; logic [4:0] a1; logic [31:0] d1;
      logic g0, g1, rwe, v0, v1, st, er;
      logic [31:0] rd; logic crd;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic r0, w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic r1, w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic g0, g1, rwe, v0, v1, st, er,
                               input logic [31:0] rd, input logic crd);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.rwe = rwe; v.v0 = v0; v.v1 = v1; v.st = st; v.er = er;
      v.rd = rd; v.crd = crd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
      end
   endtask

   task automatic drive(input logic r0, w0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic r1, w1, input logic [4:0] a1, input logic [31:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 1'b0, 5'd3, 32'h0, 1'b1, 1'b1, 5'd4, 32'h0);
      #2;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_raddr", 32'(ram_raddr), 32'd0);
      chk("rst_rvalid", 32'({rvalid0, rvalid1, rstale, err}), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      //           r0 w0  a0     d0             r1 w1  a1     d1        g0 g1 we v0 v1 st er  rdata        crd
      tbl[0]  = mk(1, 1, 5'd3,  32'h33,        1, 1, 5'd5,  32'h55,   1, 0, 1, 0, 0, 0, 0, 32'h0,        0);
      tbl[1]  = mk(1, 1, 5'd3,  32'h33,        1, 1, 5'd5,  32'h55,   0, 1, 1, 0, 0, 0, 0, 32'h0,        0);
      tbl[2]  = mk(1, 1, 5'd7,  32'hA5A5A5A5,  1, 0, 5'd2,  32'h0,    1, 1, 1, 0, 1, 0, 0, 32'h10000002, 1);
      tbl[3]  = mk(1, 1, 5'd4,  32'h11,        1, 0, 5'd4,  32'h0,    1, 1, 1, 0, 1, 1, 0, 32'h10000004, 1);
      tbl[4]  = mk(0, 0, 5'd0,  32'h0,         1, 0, 5'd4,  32'h0,    0, 1, 0, 0, 1, 0, 0, 32'h11,       1);
      tbl[5]  = mk(1, 0, 5'd3,  32'h0,         1, 0, 5'd5,  32'h0,    1, 0, 0, 1, 0, 0, 0, 32'h33,       1);
      tbl[6]  = mk(1, 0, 5'd3,  32'h0,         1, 0, 5'd5,  32'h0,    0, 1, 0, 0, 1, 0, 0, 32'h55,       1);
      tbl[7]  = mk(1, 0, 5'd3,  32'h0,         1, 0, 5'd5,  32'h0,    1, 0, 0, 1, 0, 0, 0, 32'h33,       1);
      tbl[8]  = mk(1, 0, 5'd3,  32'h0,         1, 0, 5'd5,  32'h0,    0, 1, 0, 0, 1, 0, 0, 32'h55,       1);
      tbl[9]  = mk(1, 0, 5'd3,  32'h0,         1, 0, 5'd5,  32'h0,    1, 0, 0, 1, 0, 0, 0, 32'h33,       1);
      tbl[10] = mk(1, 0, 5'd3,  32'h0,         1, 0, 5'd5,  32'h0,    0, 1, 0, 0, 1, 0, 0, 32'h55,       1);
      tbl[11] = mk(1, 0, 5'd25, 32'h0,         0, 0, 5'd0,  32'h0,    1, 0, 0, 1, 0, 0, 1, 32'h0,        1);
      tbl[12] = mk(1, 1, 5'd25, 32'hDEAD,      0, 0, 5'd0,  32'h0,    1, 0, 0, 0, 0, 0, 1, 32'h0,        0);
      tbl[13] = mk(0, 1, 5'd9,  32'hBEEF,      0, 1, 5'd9,  32'hBEEF, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0);
      tbl[14] = mk(1, 0, 5'd7,  32'h0,         0, 0, 5'd0,  32'h0,    1, 0, 0, 1, 0, 0, 0, 32'hA5A5A5A5, 1);
      tbl[15] = mk(0, 0, 5'd0,  32'h0,         1, 1, 5'd19, 32'h19,   0, 1, 1, 0, 0, 0, 0, 32'h0,        0);
      tbl[16] = mk(1, 0, 5'd19, 32'h0,         1, 0, 5'd20, 32'h0,    0, 1, 0, 0, 1, 0, 1, 32'h0,        1);
      tbl[17] = mk(1, 0, 5'd19, 32'h0,         1, 0, 5'd20, 32'h0,    1, 0, 0, 1, 0, 0, 0, 32'h19,       1);

      for (int i = 0; i < 18; i++) begin
         step = i;
         drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
         @(negedge clk);
         chk("gnt0", 32'(gnt0), 32'(tbl[i].g0));
         chk("gnt1", 32'(gnt1), 32'(tbl[i].g1));
         chk("ram_we", 32'(ram_we), 32'(tbl[i].rwe));
         @(posedge clk); #1;
         chk("rvalid0", 32'(rvalid0), 32'(tbl[i].v0));
         chk("rvalid1", 32'(rvalid1), 32'(tbl[i].v1));
         chk("rstale", 32'(rstale), 32'(tbl[i].st));
         chk("err", 32'(err), 32'(tbl[i].er));
         if (tbl[i].crd) chk("rdata", rdata, tbl[i].rd);
      end

      // Idle cycle: read address holds the last granted read, nothing returns
      step = 100;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("raddr_hold", 32'(ram_raddr), 32'd19);
      chk("idle_gnt", 32'({gnt0, gnt1, ram_we}), 32'd0);
      @(posedge clk); #1;
      chk("idle_ret", 32'({rvalid0, rvalid1, rstale, err}), 32'd0);

      // Read granted, then reset lands right after the return edge
      step = 101;
      drive(1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("pre_rst_gnt0", 32'(gnt0), 32'd1);
      @(posedge clk); #1;
      chk("pre_rst_rvalid0", 32'(rvalid0), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_rvalid0", 32'(rvalid0), 32'd0);
      chk("rst_async_raddr", 32'(ram_raddr), 32'd0);
      chk("rst_async_gnt0", 32'(gnt0), 32'd0);
      drive(1'b1, 1'b0, 5'd3, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
      @(negedge clk);
      chk("rst_hold_gnt", 32'({gnt0, gnt1}), 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
      step = 102;
      drive(1'b1, 1'b0, 5'd3, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
      @(negedge clk);
      chk("post_rst_gnt0", 32'(gnt0), 32'd1);
      chk("post_rst_gnt1", 32'(gnt1), 32'd0);
      @(posedge clk); #1;
      chk("post_rst_rv0", 32'(rvalid0), 32'd1);
      chk("post_rst_rv1", 32'(rvalid1), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
